// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered results.
//
// Single-cycle ops (add/sub/logic/slt/shifts) are computed from the inputs at accept and
// registered, so back-to-back requests give one result per clock. With ALU_MULDIV_EN
// defined, opcodes 1010-1101 (mul, mulhu, divu, remu) run on an iterative radix-2 unit
// that takes DATAWIDTH steps and deasserts in_ready while it works. Without the macro
// those opcodes are single-cycle and return 0.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   request handshake; accept = in_valid && in_ready
//   ALUctrl               4-bit opcode
//   ALUsrc                1: op2 = ImmOp, 0: op2 = regOp2
//   ALUop1, regOp2, ImmOp operands
//   out_valid             one-cycle pulse marking a new ALUout/Eq
//   ALUout, Eq            registered result and op1 == op2 flag (held between pulses)
//   busy                  multicycle operation in progress
module alu_seq #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           ALUctrl,
  input  logic                 ALUsrc,
  input  logic [DATAWIDTH-1:0] ALUop1,
  input  logic [DATAWIDTH-1:0] regOp2,
  input  logic [DATAWIDTH-1:0] ImmOp,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] ALUout,
  output logic                 Eq,
  output logic                 busy
);

  localparam int unsigned ShW  = $clog2(DATAWIDTH);
  localparam int unsigned CntW = $clog2(DATAWIDTH) + 1;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] out_q, out_d;
  logic                 eq_q, eq_d;

  logic [DATAWIDTH-1:0] op2;
  logic [ShW-1:0]       shamt;
  logic                 accept;
  logic                 eq_now;
  logic [DATAWIDTH-1:0] sc_result;

  assign op2    = ALUsrc ? ImmOp : regOp2;
  assign shamt  = op2[ShW-1:0];
  assign eq_now = (ALUop1 == op2);

  // Single-cycle result, evaluated directly on the accepted inputs.
  always_comb begin
    sc_result = '0;
    case (ALUctrl)
      4'h0:    sc_result = ALUop1 + op2;
      4'h1:    sc_result = ALUop1 - op2;
      4'h2:    sc_result = ALUop1 & op2;
      4'h3:    sc_result = ALUop1 | op2;
      4'h4:    sc_result = ALUop1 ^ op2;
      4'h5:    sc_result = {{(DATAWIDTH-1){1'b0}}, $signed(ALUop1) < $signed(op2)};
      4'h6:    sc_result = {{(DATAWIDTH-1){1'b0}}, ALUop1 < op2};
      4'h7:    sc_result = ALUop1 << shamt;
      4'h8:    sc_result = ALUop1 >> shamt;
      4'h9:    sc_result = $unsigned($signed(ALUop1) >>> shamt);
      default: sc_result = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared 2*DATAWIDTH working register.
  //   mul: {partial product high, remaining multiplier bits}, shifted right each step.
  //   div: {partial remainder, remaining dividend / growing quotient}, shifted left.
  logic [2*DATAWIDTH-1:0] acc_q, acc_d;
  logic [DATAWIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   hi_q, hi_d;       // result comes from the upper half
  logic                   div_q, div_d;     // divide step rather than multiply step
  logic                   pend_q, pend_d;   // Eq captured at accept, published at finish

  logic                   is_muldiv;
  logic [DATAWIDTH:0]     mul_sum;
  logic [2*DATAWIDTH-1:0] mul_next;
  logic [DATAWIDTH:0]     div_shift;
  logic [DATAWIDTH-1:0]   div_diff;
  logic                   div_ge;
  logic [2*DATAWIDTH-1:0] div_next;
  logic [2*DATAWIDTH-1:0] step_next;

  assign is_muldiv = (ALUctrl >= 4'hA) && (ALUctrl <= 4'hD);

  assign mul_sum  = {1'b0, acc_q[2*DATAWIDTH-1:DATAWIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATAWIDTH-1:1]};

  // Restoring divide; a zero divisor always "fits", which yields all-ones quotient and
  // leaves the dividend in the remainder half.
  assign div_shift = acc_q[2*DATAWIDTH-1:DATAWIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[DATAWIDTH-1:0] - opnd_q;
  assign div_next  = div_ge ? {div_diff, acc_q[DATAWIDTH-2:0], 1'b1}
                            : {div_shift[DATAWIDTH-1:0], acc_q[DATAWIDTH-2:0], 1'b0};

  assign step_next = div_q ? div_next : mul_next;

  assign in_ready = (state_q != StBusy);
  assign busy     = (state_q == StBusy);
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign ALUout    = out_q;
  assign Eq        = eq_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    eq_d    = eq_q;
`ifdef ALU_MULDIV_EN
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    div_d   = div_q;
    pend_d  = pend_q;
`endif
    case (state_q)
`ifdef ALU_MULDIV_EN
      StBusy: begin
        acc_d = step_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          // mul/divu take the low half, mulhu/remu the high half (opcode bit 0).
          out_d   = hi_q ? step_next[2*DATAWIDTH-1:DATAWIDTH] : step_next[DATAWIDTH-1:0];
          eq_d    = pend_q;
        end
      end
`endif
      default: begin  // StIdle, StDone
        state_d = StIdle;
        if (accept) begin
          state_d = StDone;
          out_d   = sc_result;
          eq_d    = eq_now;
`ifdef ALU_MULDIV_EN
          if (is_muldiv) begin
            state_d = StBusy;
            out_d   = out_q;
            eq_d    = eq_q;
            acc_d   = {{DATAWIDTH{1'b0}}, ALUop1};
            opnd_d  = op2;
            cnt_d   = CntW'(DATAWIDTH);
            hi_d    = ALUctrl[0];
            div_d   = ALUctrl[2];
            pend_d  = eq_now;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      eq_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      div_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      eq_q    <= eq_d;
`ifdef ALU_MULDIV_EN
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DATAWIDTH = 32). Works with or without ALU_MULDIV_EN.
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit HasMd = 1'b1;
`else
  localparam bit HasMd = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   ALUctrl = '0;
  logic         ALUsrc = 1'b0;
  logic [W-1:0] ALUop1 = '0;
  logic [W-1:0] regOp2 = '0;
  logic [W-1:0] ImmOp = '0;
  logic         out_valid;
  logic [W-1:0] ALUout;
  logic         Eq;
  logic         busy;

  alu_seq #(.DATAWIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUctrl  (ALUctrl),
    .ALUsrc   (ALUsrc),
    .ALUop1   (ALUop1),
    .regOp2   (regOp2),
    .ImmOp    (ImmOp),
    .out_valid(out_valid),
    .ALUout   (ALUout),
    .Eq       (Eq),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         eq;
    int           due;
  } exp_t;

  typedef struct {
    logic [3:0]   c;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] r2;
    logic [W-1:0] imm;
    logic [W-1:0] er;
    logic         ee;
  } vec_t;

  exp_t         q[$];
  vec_t         tab[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           busy_left = 0;
  logic [W-1:0] last_out = '0;
  logic         last_eq = 1'b0;
  logic [W-1:0] pend_res = '0;
  logic         pend_eq = 1'b0;
  logic         last_acc = 1'b0;

  // Reference: the opcode table in plain arithmetic.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [4:0]     sh;
    sh = b[4:0];
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h6: return (a < b) ? 1 : 0;
      4'h7: return a << sh;
      4'h8: return a >> sh;
      4'h9: return $unsigned($signed(a) >>> sh);
      4'hA: return HasMd ? p[W-1:0] : '0;
      4'hB: return HasMd ? p[2*W-1:W] : '0;
      4'hC: return HasMd ? ((b == 0) ? '1 : a / b) : '0;
      4'hD: return HasMd ? ((b == 0) ? a : a % b) : '0;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, update the model, then check every output 1 ns after the edge.
  task automatic tick();
    logic acc;
    logic md;
    exp_t e;
    acc = in_valid && (busy_left == 0) && !rst;
    md  = HasMd && (ALUctrl >= 4'hA) && (ALUctrl <= 4'hD);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      busy_left = 0;
      last_out  = '0;
      last_eq   = 1'b0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (acc) begin
        e.res = pend_res;
        e.eq  = pend_eq;
        e.due = md ? cyc + W : cyc;
        q.push_back(e);
        if (md) busy_left = W;
      end
    end
    last_acc = acc && !rst;
    #1;
    chk("in_ready", W'(in_ready), W'(busy_left == 0));
    chk("busy", W'(busy), W'(busy_left > 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", W'(out_valid), W'(1));
      chk("ALUout", ALUout, e.res);
      chk("Eq", W'(Eq), W'(e.eq));
      last_out = e.res;
      last_eq  = e.eq;
    end else begin
      chk("out_valid_idle", W'(out_valid), W'(0));
      chk("ALUout_hold", ALUout, last_out);
      chk("Eq_hold", W'(Eq), W'(last_eq));
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] r2, input logic [W-1:0] imm,
                       input logic [W-1:0] er, input logic ee);
    ALUctrl  = c;
    ALUsrc   = s;
    ALUop1   = a;
    regOp2   = r2;
    ImmOp    = imm;
    pend_res = er;
    pend_eq  = ee;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, expected accept of opcode %h", c);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < W + 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic add_vec(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] r2, input logic [W-1:0] imm,
                         input logic [W-1:0] er, input logic ee);
    vec_t v;
    v.c = c; v.s = s; v.a = a; v.r2 = r2; v.imm = imm; v.er = er; v.ee = ee;
    tab.push_back(v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   c;
    logic         s;
    logic [W-1:0] a, r2, imm, b;

    // Expected values written out by hand.
    add_vec(4'h0, 1'b0, 32'd5,         32'd7,  32'd0,      32'd12,        1'b0);
    add_vec(4'h1, 1'b1, 32'd5,         32'd0,  32'd5,      32'd0,         1'b1);
    add_vec(4'h9, 1'b0, 32'h8000_0000, 32'd4,  32'd0,      32'hF800_0000, 1'b0);
    add_vec(4'h5, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,      32'd1,         1'b0);
    add_vec(4'h6, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,      32'd0,         1'b0);
    add_vec(4'h7, 1'b0, 32'd1,         32'd33, 32'd0,      32'd2,         1'b0);
    add_vec(4'h8, 1'b0, 32'h8000_0000, 32'd4,  32'd0,      32'h0800_0000, 1'b0);
    add_vec(4'h2, 1'b1, 32'hF0F0,      32'd0,  32'hFF00,   32'hF000,      1'b0);
    add_vec(4'h3, 1'b1, 32'hF0F0,      32'd0,  32'hFF00,   32'hFFF0,      1'b0);
    add_vec(4'h4, 1'b1, 32'hF0F0,      32'd0,  32'hFF00,   32'h0FF0,      1'b0);
    add_vec(4'h0, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,      32'd0,         1'b0);
    add_vec(4'hE, 1'b0, 32'd3,         32'd3,  32'd0,      32'd0,         1'b1);
    add_vec(4'hF, 1'b1, 32'd7,         32'd0,  32'd7,      32'd0,         1'b1);
    add_vec(4'hA, 1'b0, 32'hFFFF_FFFF, 32'd2,  32'd0,      HasMd ? 32'hFFFF_FFFE : 32'd0, 1'b0);
    add_vec(4'hB, 1'b0, 32'hFFFF_FFFF, 32'd2,  32'd0,      HasMd ? 32'd1 : 32'd0,  1'b0);
    add_vec(4'hC, 1'b0, 32'd100,       32'd7,  32'd0,      HasMd ? 32'd14 : 32'd0, 1'b0);
    add_vec(4'hD, 1'b0, 32'd100,       32'd7,  32'd0,      HasMd ? 32'd2 : 32'd0,  1'b0);
    add_vec(4'hC, 1'b0, 32'hDEAD_BEEF, 32'd0,  32'd0,      HasMd ? 32'hFFFF_FFFF : 32'd0, 1'b0);
    add_vec(4'hD, 1'b0, 32'd9,         32'd0,  32'd0,      HasMd ? 32'd9 : 32'd0,  1'b0);
    add_vec(4'hA, 1'b0, 32'd3,         32'd3,  32'd0,      HasMd ? 32'd9 : 32'd0,  1'b1);

    // Reset for two cycles with a request present: rst must win.
    in_valid = 1'b1;
    ALUctrl  = 4'h0;
    ALUop1   = 32'd1;
    regOp2   = 32'd1;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // Table, issued back to back (multicycle entries stall via in_ready).
    for (int i = 0; i < tab.size(); i++)
      issue(tab[i].c, tab[i].s, tab[i].a, tab[i].r2, tab[i].imm, tab[i].er, tab[i].ee);
    drain();

`ifdef ALU_MULDIV_EN
    // Abort a divide with rst on its tenth cycle, then issue an add straight away.
    issue(4'hC, 1'b0, 32'd1000, 32'd3, 32'd0, 32'd333, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(4'h0, 1'b0, 32'd20, 32'd22, 32'd0, 32'd42, 1'b0);
    drain();
`endif

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      c   = 4'($urandom_range(0, 15));
      s   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      r2  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      b   = s ? imm : r2;
      issue(c, s, a, r2, imm, ref_alu(c, a, b), a == b);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
